// File: rtl/frame_pkg.sv
// Shared types and constants for the frame packer: FSM state encoding,
// default sync bytes and the frame length helper.
package frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC0 = 3'd1,
    ST_SYNC1 = 3'd2,
    ST_SEQ   = 3'd3,
    ST_DATA  = 3'd4,
    ST_CSUM  = 3'd5
  } state_e;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

  // Number of data_adcN ports physically present on the packer.
  localparam int MAX_CH = 6;

  // Total bytes on the wire: two sync bytes, SEQ, channel payload, CSUM.
  function automatic int frame_bytes(input int n_ch, input int width);
    return 4 + (n_ch * width) / 8;
  endfunction

endpackage

// File: rtl/frame_csum.sv
// Running 8-bit modular checksum of the SEQ and payload bytes of one frame.
module frame_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] add_byte,
  output logic [7:0] sum
);

  logic [7:0] acc_q;
  logic [7:0] acc_d;

  // Clear wins so a back-to-back frame starts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + add_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum = acc_q;

endmodule

// File: rtl/frame_packer.sv
// Packs one snapshot of the filtered channel words per word_clk rising edge
// into a SYNC0/SYNC1/SEQ/payload/CSUM byte stream for the UART transmitter.
module frame_packer
  import frame_pkg::*;
#(
  parameter int         WIDTH = 16,
  parameter int         N_CH  = 6,
  parameter logic [7:0] SYNC0 = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1 = SYNC1_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] data_adc0,
  input  logic [WIDTH-1:0] data_adc1,
  input  logic [WIDTH-1:0] data_adc2,
  input  logic [WIDTH-1:0] data_adc3,
  input  logic [WIDTH-1:0] data_adc4,
  input  logic [WIDTH-1:0] data_adc5,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             sync_pulse,
  output logic             busy,
  output logic             overrun,
  output state_e           state_dbg
);

  localparam int BPC        = WIDTH / 8;
  localparam int DATA_BYTES = N_CH * BPC;
  localparam int IDX_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  // Valid/ready: a byte moves on every cycle with tx_valid & tx_ready high;
  // while tx_valid is high and tx_ready low, tx_data holds its value.

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [7:0]         seq_q, seq_d;
  logic               we_q;
  logic               sync_pulse_q, sync_pulse_d;
  logic               overrun_q, overrun_d;
  logic [WIDTH-1:0]   snap_q [N_CH];
  logic [WIDTH-1:0]   snap_d [N_CH];
  logic [WIDTH-1:0]   adc_in [MAX_CH];

  logic               rise;
  logic               hs;
  logic               accept;
  logic               csum_add;
  logic [7:0]         csum;
  logic [7:0]         data_byte;

  always_comb begin
    adc_in[0] = data_adc0;
    adc_in[1] = data_adc1;
    adc_in[2] = data_adc2;
    adc_in[3] = data_adc3;
    adc_in[4] = data_adc4;
    adc_in[5] = data_adc5;
  end

  assign tx_valid   = (state_q != ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign sync_pulse = sync_pulse_q;
  assign overrun    = overrun_q;
  assign state_dbg  = state_q;

  assign rise = write_enable & ~we_q;
  assign hs   = tx_valid & tx_ready;

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    seq_d        = seq_q;
    snap_d       = snap_q;
    sync_pulse_d = 1'b0;
    overrun_d    = 1'b0;
    accept       = 1'b0;
    csum_add     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise) accept = 1'b1;
      end
      ST_SYNC0: begin
        if (hs) state_d = ST_SYNC1;
      end
      ST_SYNC1: begin
        if (hs) state_d = ST_SEQ;
      end
      ST_SEQ: begin
        if (hs) begin
          state_d    = ST_DATA;
          byte_idx_d = '0;
          csum_add   = 1'b1;
        end
      end
      ST_DATA: begin
        if (hs) begin
          csum_add = 1'b1;
          if (byte_idx_q == IDX_W'(DATA_BYTES - 1)) begin
            state_d = ST_CSUM;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      ST_CSUM: begin
        if (hs) begin
          seq_d   = seq_q + 8'd1;
          state_d = ST_IDLE;
          // A new sample set landing exactly as CSUM leaves is chained, not dropped.
          if (rise) accept = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d      = ST_SYNC0;
      sync_pulse_d = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        snap_d[c] = adc_in[c];
      end
    end else if (rise && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // Payload byte k is byte (k % BPC) of channel (k / BPC), MSB byte first.
  always_comb begin
    data_byte = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int b = 0; b < BPC; b++) begin
        if (byte_idx_q == IDX_W'(c * BPC + b)) begin
          data_byte = snap_q[c][WIDTH-1-8*b -: 8];
        end
      end
    end
  end

  always_comb begin
    tx_data = '0;
    case (state_q)
      ST_SYNC0: tx_data = SYNC0;
      ST_SYNC1: tx_data = SYNC1;
      ST_SEQ:   tx_data = seq_q;
      ST_DATA:  tx_data = data_byte;
      ST_CSUM:  tx_data = csum;
      default:  tx_data = '0;
    endcase
  end

  frame_csum u_csum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .add_en   (csum_add),
    .add_byte (tx_data),
    .sum      (csum)
  );

  // we_q resets high so a word_clk already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= '0;
      seq_q        <= '0;
      we_q         <= 1'b1;
      sync_pulse_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        snap_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      seq_q        <= seq_d;
      we_q         <= write_enable;
      sync_pulse_q <= sync_pulse_d;
      overrun_q    <= overrun_d;
      for (int c = 0; c < N_CH; c++) begin
        snap_q[c] <= snap_d[c];
      end
    end
  end

endmodule
